// File: rtl/aes_sbox_pkg.sv
// AES S-box constants shared by the lane lookup and the pipeline top.
// Tables are indexed by the input byte; entry 0 is listed first.
package aes_sbox_pkg;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX_FWD[b];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return SBOX_INV[b];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// Single-byte combinational S-box lookup; the inverse table exists only when INV_EN is set.
module aes_sbox_lane
    import aes_sbox_pkg::*;
#(
    parameter int INV_EN = 1
) (
    input  logic       mode,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] fwd_byte;
    logic [7:0] inv_byte;

    assign fwd_byte = sbox_fwd(din);

    generate
        if (INV_EN != 0) begin : g_inv
            assign inv_byte = sbox_inv(din);
        end else begin : g_no_inv
            assign inv_byte = 8'h00;
        end
    endgenerate

    assign dout = ((INV_EN != 0) && (mode == MODE_INV)) ? inv_byte : fwd_byte;

endmodule

// File: rtl/aes_sbox_pipe.sv
// Multi-lane pipelined AES SubBytes/InvSubBytes unit with valid/ready flow control.
// Stage 1 registers the lookup; later stages are pure delay with collapsing bubbles.
module aes_sbox_pipe
    import aes_sbox_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2,
    parameter int INV_EN      = 1,
    parameter int TAG_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_mode,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int W = 8 * LANES;

    // Handshake: a transfer happens on each rising edge where valid && ready are both
    // high; the producer holds valid and payload until that edge, ready may depend
    // combinationally on downstream ready.

    logic                mode_eff;
    logic [W-1:0]        lookup;
    logic [PIPE_STAGES:1]     v;
    logic [W-1:0]        d_q [1:PIPE_STAGES];
    logic                m_q [1:PIPE_STAGES];
    logic [TAG_W-1:0]    t_q [1:PIPE_STAGES];
    logic [PIPE_STAGES+1:1]   en;

    assign mode_eff = (INV_EN != 0) ? in_mode : MODE_FWD;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            aes_sbox_lane #(.INV_EN(INV_EN)) u_lane (
                .mode (mode_eff),
                .din  (in_data[8*k +: 8]),
                .dout (lookup[8*k +: 8])
            );
        end
    endgenerate

    // en[i]: stage i may take new contents this cycle (empty, or its current contents leave).
    always_comb begin
        en = '0;
        en[PIPE_STAGES+1] = out_ready;
        for (int i = PIPE_STAGES; i >= 1; i--) begin
            en[i] = !v[i] || en[i+1];
        end
    end

    assign in_ready = en[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
            for (int i = 1; i <= PIPE_STAGES; i++) begin
                d_q[i] <= '0;
                m_q[i] <= 1'b0;
                t_q[i] <= '0;
            end
        end else begin
            if (en[1]) begin
                v[1] <= in_valid;
                if (in_valid) begin
                    d_q[1] <= lookup;
                    m_q[1] <= mode_eff;
                    t_q[1] <= in_tag;
                end
            end
            for (int i = 2; i <= PIPE_STAGES; i++) begin
                if (en[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        d_q[i] <= d_q[i-1];
                        m_q[i] <= m_q[i-1];
                        t_q[i] <= t_q[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = v[PIPE_STAGES];
    assign out_data  = d_q[PIPE_STAGES];
    assign out_mode  = m_q[PIPE_STAGES];
    assign out_tag   = t_q[PIPE_STAGES];
    assign busy      = |v;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Self-checking bench for aes_sbox_pipe: table vectors, streaming sweep, backpressure,
// random traffic against a GF(2^8) reference model, reset mid-flight, and parameter variants.
module tb_aes_sbox_pipe;

    logic clk;
    logic reset_n;

    // main instance: LANES=4, PIPE_STAGES=2, INV_EN=1
    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, busy;
    logic [31:0] in_data, out_data;
    logic [3:0]  in_tag, out_tag;

    // variant A: LANES=16, PIPE_STAGES=4, INV_EN=0
    logic         a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_mode, a_busy;
    logic [127:0] a_in_data, a_out_data;
    logic [3:0]   a_in_tag, a_out_tag;

    // variant B: LANES=1, PIPE_STAGES=1, INV_EN=1
    logic         b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_mode, b_busy;
    logic [7:0]   b_in_data, b_out_data;
    logic [3:0]   b_in_tag, b_out_tag;

    aes_sbox_pipe #(.LANES(4), .PIPE_STAGES(2), .INV_EN(1), .TAG_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .out_tag(out_tag), .busy(busy)
    );

    aes_sbox_pipe #(.LANES(16), .PIPE_STAGES(4), .INV_EN(0), .TAG_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
        .in_data(a_in_data), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(1'b1), .out_data(a_out_data),
        .out_mode(a_out_mode), .out_tag(a_out_tag), .busy(a_busy)
    );

    aes_sbox_pipe #(.LANES(1), .PIPE_STAGES(1), .INV_EN(1), .TAG_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
        .in_data(b_in_data), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
        .out_mode(b_out_mode), .out_tag(b_out_tag), .busy(b_busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- counters / scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;
    logic [36:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model (GF(2^8) definition of the S-box) ----------------
    logic [7:0] ref_fwd [256];
    logic [7:0] ref_inv [256];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_ref();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            if (x == 0) inv = 8'h00;
            else for (int e = 0; e < 254; e++) inv = gf_mul(inv, 8'(x));
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            ref_fwd[x] = s;
            ref_inv[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_word(input logic [127:0] d, input logic m,
                                                input int lanes, input int inv_en);
        logic [127:0] r = '0;
        logic [7:0] b;
        for (int k = 0; k < lanes; k++) begin
            b = d[8*k +: 8];
            r[8*k +: 8] = (m && inv_en != 0) ? ref_inv[b] : ref_fwd[b];
        end
        return r;
    endfunction

    function automatic logic [31:0] model4(input logic [31:0] d, input logic m);
        logic [127:0] r;
        r = model_word({96'b0, d}, m, 4, 1);
        return r[31:0];
    endfunction

    // ---------------- driver ----------------
    task automatic idle_cycle();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_tag   = 4'($urandom);
        in_mode  = 1'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] d, input logic m, input logic [3:0] t, input logic [31:0] expd);
        bit ok = 0;
        in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
            if (k == 0) stall_cnt++;
        end
        if (ok) begin
            exp_q.push_back({m, t, expd});
            @(posedge clk); #1;
        end else begin
            checks++; failures++;
            $display("FAIL send_timeout got=in_ready_low exp=accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int k = 0; k < max_cycles && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    // ---------------- monitor ----------------
    logic [36:0] hold_val;
    bit          hold_valid = 0;

    initial begin
        logic [36:0] cur, e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold_valid = 0;
            end else begin
                cur = {out_mode, out_tag, out_data};
                if (hold_valid) begin
                    if (out_valid) check("hold_stable", 128'(cur), 128'(hold_val));
                    else           check("hold_valid_drop", 128'(out_valid), 128'd1);
                end
                hold_valid = 0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output got=%h exp=none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_result", 128'(cur), 128'(e));
                    end
                end else if (out_valid) begin
                    hold_valid = 1;
                    hold_val   = cur;
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    typedef struct {
        logic [31:0] data;
        logic        mode;
        logic [31:0] expd;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int lat;
        int stall_base;
        int seen;
        bit done;
        logic [31:0] d, ea;
        logic [127:0] wa, ew;
        logic [7:0] bd;
        logic bm;

        vecs[0] = '{32'hFF_53_01_00, 1'b0, 32'h16_ED_7C_63};
        vecs[1] = '{32'h16_ED_7C_63, 1'b1, 32'hFF_53_01_00};
        vecs[2] = '{32'h00_00_00_00, 1'b0, 32'h63_63_63_63};
        vecs[3] = '{32'h03_02_01_00, 1'b1, 32'hD5_6A_09_52};
        vecs[4] = '{32'h13_12_11_10, 1'b0, 32'h7D_C9_82_CA};

        build_ref();

        reset_n = 1'b1;
        in_valid = 0; in_mode = 0; in_data = '0; in_tag = '0; out_ready = 1'b1;
        a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_in_tag = '0;
        b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_in_tag = '0;
        #2 reset_n = 1'b0;
        #1;
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_busy",      128'(busy),      128'd0);
        check("reset_out_data",  128'(out_data),  128'd0);
        check("reset_out_mode",  128'(out_mode),  128'd0);
        check("reset_out_tag",   128'(out_tag),   128'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        #1 check("reset_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;

        // table vectors, one at a time, with latency measurement
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].data, vecs[i].mode, 4'(i + 3), vecs[i].expd);
            lat = 1;
            while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            check("vec_latency", 128'(lat), 128'd2);
            @(posedge clk); #1;
        end
        wait_drain(20);

        // streaming sweep: all 256 bytes in both modes, modes alternating per transfer
        stall_base = stall_cnt;
        for (int i = 0; i < 128; i++) begin
            d = {8'(4*(i>>1)+3), 8'(4*(i>>1)+2), 8'(4*(i>>1)+1), 8'(4*(i>>1))};
            send(d, 1'(i), 4'(i), model4(d, 1'(i)));
            if (i >= 1) check("stream_out_valid", 128'(out_valid), 128'd1);
        end
        check("stream_no_stall", 128'(stall_cnt - stall_base), 128'd0);
        wait_drain(20);

        // backpressure: fill with out_ready low, hold 5 cycles
        out_ready = 1'b0;
        ea = model4(32'hA5_5A_C3_3C, 1'b1);
        send(32'hA5_5A_C3_3C, 1'b1, 4'hB, ea);
        send(32'h01_23_45_67, 1'b0, 4'hC, model4(32'h01_23_45_67, 1'b0));
        check("bp_in_ready_low", 128'(in_ready), 128'd0);
        check("bp_busy", 128'(busy), 128'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_held", 128'({out_mode, out_tag, out_data}), 128'({1'b1, 4'hB, ea}));
        end
        out_ready = 1'b1;
        wait_drain(20);

        // random traffic with random backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) idle_cycle();
                    d  = $urandom;
                    bm = 1'($urandom);
                    send(d, bm, 4'($urandom), model4(d, bm));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain(50);

        // reset with two results in flight
        out_ready = 1'b0;
        send(32'hDE_AD_BE_EF, 1'b1, 4'hE, model4(32'hDE_AD_BE_EF, 1'b1));
        send(32'h12_34_56_78, 1'b1, 4'hD, model4(32'h12_34_56_78, 1'b1));
        check("pre_reset_busy", 128'(busy), 128'd1);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_busy",      128'(busy),      128'd0);
        check("midrst_out_data",  128'(out_data),  128'd0);
        check("midrst_out_mode",  128'(out_mode),  128'd0);
        check("midrst_out_tag",   128'(out_tag),   128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        out_ready = 1'b1;
        #1 check("postrst_in_ready", 128'(in_ready), 128'd1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("postrst_no_stale", 128'(seen), 128'd0);

        // variant A: 16 lanes, 4 stages, forward only (mode=1 still gives forward, out_mode=0)
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            wa = {$urandom, $urandom, $urandom, $urandom};
            a_in_valid = 1'b1; a_in_mode = 1'b1; a_in_data = wa; a_in_tag = 4'(n + 9);
            @(negedge clk);
            check("a_in_ready", 128'(a_in_ready), 128'd1);
            @(posedge clk); #1;
            a_in_valid = 1'b0;
            for (int k = 1; k < 4; k++) begin
                check("a_early_valid", 128'(a_out_valid), 128'd0);
                @(posedge clk); #1;
            end
            ew = model_word(wa, 1'b1, 16, 0);
            check("a_out_valid", 128'(a_out_valid), 128'd1);
            check("a_out_data",  a_out_data, ew);
            check("a_out_mode",  128'(a_out_mode), 128'd0);
            check("a_out_tag",   128'(a_out_tag), 128'(n + 9));
        end
        @(posedge clk); #1;
        check("a_idle_busy", 128'(a_busy), 128'd0);

        // variant B: 1 lane, 1 stage, streaming random bytes and modes
        for (int n = 0; n < 16; n++) begin
            bd = 8'($urandom); bm = 1'($urandom);
            b_in_valid = 1'b1; b_in_mode = bm; b_in_data = bd; b_in_tag = 4'(n);
            @(negedge clk);
            check("b_in_ready", 128'(b_in_ready), 128'd1);
            @(posedge clk); #1;
            ew = model_word({120'b0, bd}, bm, 1, 1);
            check("b_out_valid", 128'(b_out_valid), 128'd1);
            check("b_out_data",  128'(b_out_data), ew);
            check("b_out_mode_tag", 128'({b_out_mode, b_out_tag}), 128'({bm, 4'(n)}));
        end
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        check("b_drop_valid", 128'(b_out_valid), 128'd0);

        check("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
